// File: rtl/mult_hilo_unit_if.sv
// mult_hilo_unit_if: execute-stage connection to the HI/LO multiply unit.
// Carries the multiply request, the MTHI/MTLO write port and the
// busy/done/HI/LO results. master = pipeline side, slave = multiply unit.
interface mult_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       acc_op;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, a, b, acc_op, hi_we, lo_we, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, a, b, acc_op, hi_we, lo_we, wr_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit: multi-cycle signed/unsigned multiplier that owns HI/LO.
// A start loads the operands and a LATENCY-edge countdown; the completion
// edge writes {HI,LO} and pulses done. MTHI/MTLO write HI/LO directly but
// lose to a product landing on the same edge.
// Optional feature macro: MULT_HILO_ACC_EN enables acc_op accumulate
// (add/subtract the product to/from {HI,LO}); when undefined every
// completion overwrites {HI,LO} and acc_op is ignored.
module mult_hilo_unit #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4     // legal 1..16
) (
    input  logic               clk,
    input  logic               reset_l,
    mult_hilo_unit_if.slave    bus
);
    localparam int CW = $clog2(LATENCY + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             complete;
    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    b_ext;
    logic [PW-1:0]    prod_s0;
    logic [PW-1:0]    prod_final;
    logic [PW-1:0]    result;

    // Operands extended to the full product width; the low PW bits of the
    // PW-bit product are the exact signed or unsigned 2*WIDTH-bit product.
    assign a_ext   = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
    assign b_ext   = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
    assign prod_s0 = a_ext * b_ext;

    // Product pipeline: LATENCY-1 register stages after the multiplier so
    // synthesis can retime it. Operands stay stable for the whole run, so
    // the last stage holds the correct product by the completion edge.
    generate
        if (LATENCY == 1) begin : g_no_pipe
            assign prod_final = prod_s0;
        end else begin : g_pipe
            logic [PW-1:0] pipe_q [LATENCY-1];
            logic [PW-1:0] pipe_d [LATENCY-1];

            // Shift the product one stage per edge.
            always_comb begin
                pipe_d[0] = prod_s0;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            // NOTE: pure datapath stages carry no reset; nothing reads them
            // before the countdown has refilled them with valid data.
            always_ff @(posedge clk) begin
                for (int i = 0; i < LATENCY - 1; i++) begin
                    pipe_q[i] <= pipe_d[i];
                end
            end

            assign prod_final = pipe_q[LATENCY-2];
        end
    endgenerate

`ifdef MULT_HILO_ACC_EN
    logic [1:0] acc_q, acc_d;

    // Completion value: overwrite, or add/subtract against current {HI,LO}.
    always_comb begin
        case (acc_q)
            2'b01:   result = {hi_q, lo_q} + prod_final;
            2'b10:   result = {hi_q, lo_q} - prod_final;
            default: result = prod_final;
        endcase
    end
`else
    logic unused_acc_op;
    assign unused_acc_op = ^bus.acc_op;
    assign result        = prod_final;
`endif

    // Next-state: countdown, completion write, MTHI/MTLO, start/restart.
    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MULT_HILO_ACC_EN
        acc_d   = acc_q;
`endif

        complete = (state_q == RUN) && (cnt_q == CW'(1));

        if (state_q == RUN) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (complete) begin
            state_d = IDLE;
        end

        // Direct writes first so a same-edge product result overrides them.
        if (bus.hi_we) begin
            hi_d = bus.wr_data;
        end
        if (bus.lo_we) begin
            lo_d = bus.wr_data;
        end
        if (complete) begin
            {hi_d, lo_d} = result;
            done_d       = 1'b1;
        end

        // A start (also while busy or on the completion edge) begins afresh;
        // reloading the counter drops any in-flight completion.
        if (bus.start) begin
            a_d     = bus.a;
            b_d     = bus.b;
            sgn_d   = bus.is_signed;
            cnt_d   = CW'(LATENCY);
            state_d = RUN;
`ifdef MULT_HILO_ACC_EN
            acc_d   = bus.acc_op;
`endif
        end

        busy_d = (state_d == RUN);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULT_HILO_ACC_EN
            acc_q   <= 2'b00;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MULT_HILO_ACC_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb_mult_hilo_unit: table-driven and randomized checks of mult_hilo_unit
// (WIDTH 32, LATENCY 4). A cycle-level reference model tracks {HI,LO} as one
// 64-bit value and the pending product by its due cycle number.
module tb_mult_hilo_unit;
    localparam int WIDTH   = 32;
    localparam int LATENCY = 4;
`ifdef MULT_HILO_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic clk     = 1'b0;
    logic reset_l = 1'b0;
    always #5 clk = ~clk;

    mult_hilo_unit_if #(.WIDTH(WIDTH)) bus ();

    mult_hilo_unit #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          cyc = 0;
    logic [63:0] m_hilo;
    bit          m_valid;
    int          m_due;
    logic [63:0] m_prod;
    logic [1:0]  m_acc;
    bit          m_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_product(input bit s, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        if (s) begin
            sx = longint'(signed'(x));
            sy = longint'(signed'(y));
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    task automatic model_clear();
        m_hilo  = '0;
        m_valid = 1'b0;
        m_due   = 0;
        m_prod  = '0;
        m_acc   = 2'b00;
        m_done  = 1'b0;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".busy"}, 64'(bus.busy), 64'(m_valid));
        check({tag, ".done"}, 64'(bus.done), 64'(m_done));
        check({tag, ".hi"},   64'(bus.hi),   64'(m_hilo[63:32]));
        check({tag, ".lo"},   64'(bus.lo),   64'(m_hilo[31:0]));
    endtask

    task automatic set_idle();
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.acc_op    = 2'b00;
        bus.hi_we     = 1'b0;
        bus.lo_we     = 1'b0;
        bus.wr_data   = '0;
    endtask

    // One clock edge: advance the model with the inputs seen at the edge,
    // then compare all outputs 1 time unit later.
    task automatic tick(input string tag);
        logic [63:0] old_v, nxt;
        @(posedge clk);
        cyc++;
        if (!reset_l) begin
            model_clear();
        end else begin
            old_v = m_hilo;
            nxt   = old_v;
            if (bus.hi_we) nxt[63:32] = bus.wr_data;
            if (bus.lo_we) nxt[31:0]  = bus.wr_data;
            m_done = m_valid && (cyc == m_due);
            if (m_done) begin
                if (ACC && m_acc == 2'b01)      nxt = old_v + m_prod;
                else if (ACC && m_acc == 2'b10) nxt = old_v - m_prod;
                else                            nxt = m_prod;
                m_valid = 1'b0;
            end
            if (bus.start) begin
                m_valid = 1'b1;
                m_due   = cyc + LATENCY;
                m_prod  = ref_product(bus.is_signed, bus.a, bus.b);
                m_acc   = bus.acc_op;
            end
            m_hilo = nxt;
        end
        #1;
        compare_model(tag);
    endtask

    task automatic drive_start(input bit s, input logic [31:0] x, input logic [31:0] y, input logic [1:0] op);
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.a         = x;
        bus.b         = y;
        bus.acc_op    = op;
    endtask

    // Start one op from idle and wait (bounded) for its completion.
    task automatic run_op(input string tag, input bit s, input logic [31:0] x,
                          input logic [31:0] y, input logic [1:0] op);
        int busy_cnt, done_cnt, n;
        busy_cnt = 0;
        done_cnt = 0;
        drive_start(s, x, y, op);
        tick({tag, ".start"});
        set_idle();
        if (bus.busy) busy_cnt++;
        n = 0;
        while (done_cnt == 0 && n < 20) begin
            tick(tag);
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
            n++;
        end
        tick({tag, ".after"});
        if (bus.done) done_cnt++;
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(LATENCY));
        check({tag, ".done_pulses"}, 64'(done_cnt), 64'd1);
    endtask

    typedef struct {
        string       name;
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [31:0] pick_operand();
        logic [31:0] corner [5];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;
        if ($urandom_range(3) == 0) return corner[$urandom_range(4)];
        return $urandom;
    endfunction

    initial begin
        int dcnt;
        vecs[0] = '{"s_m2x3",   1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{"u_m2x3",   1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2] = '{"s_min2",   1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3] = '{"u_max2",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[4] = '{"s_maxmin", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
        vecs[5] = '{"s_m1m1",   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[6] = '{"u_zero",   1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};
        vecs[7] = '{"u_small",  1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

        set_idle();
        model_clear();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset.hi",   64'(bus.hi),   64'd0);
        check("reset.lo",   64'(bus.lo),   64'd0);
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        reset_l = 1'b1;
        tick("post_reset");

        // Table-driven single operations against hand-computed results
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].name, vecs[i].s, vecs[i].a, vecs[i].b, 2'b00);
            check({vecs[i].name, ".hi_const"}, 64'(bus.hi), 64'(vecs[i].hi));
            check({vecs[i].name, ".lo_const"}, 64'(bus.lo), 64'(vecs[i].lo));
        end

        // Restart while busy: 5x7 then 3x3 two edges later
        drive_start(1'b0, 32'd5, 32'd7, 2'b00);
        tick("restart.s1");
        set_idle();
        tick("restart.gap");
        drive_start(1'b0, 32'd3, 32'd3, 2'b00);
        tick("restart.s2");
        set_idle();
        dcnt = 0;
        for (int i = 0; i < LATENCY - 1; i++) begin
            tick("restart.wait");
            if (bus.done) dcnt++;
        end
        check("restart.no_old_done", 64'(dcnt), 64'd0);
        tick("restart.complete");
        check("restart.done", 64'(bus.done), 64'd1);
        check("restart.lo",   64'(bus.lo),   64'd9);
        check("restart.hi",   64'(bus.hi),   64'd0);

        // MTLO on the completion edge loses to the product
        drive_start(1'b0, 32'd2, 32'd2, 2'b00);
        tick("mtlo_col.start");
        set_idle();
        repeat (LATENCY - 1) tick("mtlo_col.wait");
        bus.lo_we   = 1'b1;
        bus.wr_data = 32'h1234;
        tick("mtlo_col.edge");
        set_idle();
        check("mtlo_col.lo",   64'(bus.lo),   64'd4);
        check("mtlo_col.done", 64'(bus.done), 64'd1);

        // MTLO two edges before completion is overwritten by the completion
        drive_start(1'b0, 32'd2, 32'd2, 2'b00);
        tick("mtlo_early.start");
        set_idle();
        tick("mtlo_early.wait");
        bus.lo_we   = 1'b1;
        bus.wr_data = 32'h1234;
        tick("mtlo_early.write");
        set_idle();
        check("mtlo_early.lo_written", 64'(bus.lo), 64'h1234);
        tick("mtlo_early.wait2");
        tick("mtlo_early.complete");
        check("mtlo_early.lo", 64'(bus.lo), 64'd4);

        // Start on the completion edge: old result lands, new op runs on
        drive_start(1'b1, 32'hFFFF_FFFF, 32'd6, 2'b00);
        tick("overlap.s1");
        set_idle();
        repeat (LATENCY - 1) tick("overlap.wait");
        drive_start(1'b0, 32'd10, 32'd10, 2'b00);
        tick("overlap.edge");
        set_idle();
        check("overlap.done", 64'(bus.done), 64'd1);
        check("overlap.busy", 64'(bus.busy), 64'd1);
        check("overlap.lo",   64'(bus.lo),   64'hFFFF_FFFA);
        repeat (LATENCY) tick("overlap.run2");
        check("overlap.lo2",  64'(bus.lo),   64'd100);

`ifdef MULT_HILO_ACC_EN
        // Accumulate add and subtract
        bus.hi_we   = 1'b1;
        bus.wr_data = 32'd0;
        tick("acc.mthi");
        set_idle();
        bus.lo_we   = 1'b1;
        bus.wr_data = 32'd10;
        tick("acc.mtlo");
        set_idle();
        run_op("acc.add", 1'b0, 32'd2, 32'd3, 2'b01);
        check("acc.add.hi", 64'(bus.hi), 64'd0);
        check("acc.add.lo", 64'(bus.lo), 64'd16);
        run_op("acc.sub", 1'b1, 32'd4, 32'd5, 2'b10);
        check("acc.sub.hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFC);
`endif

        // Reset asserted mid-run abandons the operation
        drive_start(1'b0, 32'd9, 32'd9, 2'b00);
        tick("rst_mid.start");
        set_idle();
        tick("rst_mid.run");
        #2;
        reset_l = 1'b0;
        model_clear();
        #1;
        check("rst_mid.hi",   64'(bus.hi),   64'd0);
        check("rst_mid.lo",   64'(bus.lo),   64'd0);
        check("rst_mid.busy", 64'(bus.busy), 64'd0);
        check("rst_mid.done", 64'(bus.done), 64'd0);
        tick("rst_mid.held");
        reset_l = 1'b1;
        dcnt = 0;
        for (int i = 0; i < LATENCY + 2; i++) begin
            tick("rst_mid.after");
            if (bus.done) dcnt++;
        end
        check("rst_mid.no_done", 64'(dcnt), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.start     = ($urandom_range(5) == 0);
            bus.is_signed = 1'($urandom_range(1));
            bus.a         = pick_operand();
            bus.b         = pick_operand();
            bus.acc_op    = 2'($urandom_range(3));
            bus.hi_we     = ($urandom_range(7) == 0);
            bus.lo_we     = ($urandom_range(7) == 0);
            bus.wr_data   = $urandom;
            tick("rand");
        end
        set_idle();
        repeat (LATENCY + 1) tick("drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
